// File: rtl/tower_grid_scheduler_pkg.sv
// Shared grid geometry and the scheduler state encoding used by the
// tower scheduler and the neighbouring sprite draw blocks.
package tower_grid_scheduler_pkg;

    localparam int GRID_W  = 8;
    localparam int GRID_H  = 6;
    localparam int CELL_PX = 20;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_START,
        ST_WAIT,
        ST_FINISH
    } sched_state_t;

endpackage

// File: rtl/tower_grid_scheduler_occupancy_map.sv
// Occupancy bit array with bounds-checked write decode, a combinational
// read port for the scanner, and a running count of occupied cells.
module occupancy_map
    import tower_grid_scheduler_pkg::*;
#(
    parameter int GRID_W = tower_grid_scheduler_pkg::GRID_W,
    parameter int GRID_H = tower_grid_scheduler_pkg::GRID_H
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       place_valid,
    input  logic       place_set,
    input  logic [3:0] place_x,
    input  logic [3:0] place_y,
    input  logic [3:0] rd_x,
    input  logic [3:0] rd_y,
    output logic       rd_bit,
    output logic [5:0] tower_count
);

    localparam int CELLS = GRID_W * GRID_H;
    localparam int IDX_W = $clog2(CELLS);

    logic [CELLS-1:0] map;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic             in_range;

    always_comb begin
        in_range = (32'(place_x) < GRID_W) && (32'(place_y) < GRID_H);
        wr_idx   = IDX_W'(32'(place_y) * GRID_W + 32'(place_x));
        rd_idx   = IDX_W'(32'(rd_y) * GRID_W + 32'(rd_x));
        rd_bit   = map[rd_idx];
    end

    // The count only moves on a real bit transition, so redundant writes are free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            map         <= '0;
            tower_count <= '0;
        end else if (place_valid && in_range) begin
            if (place_set && !map[wr_idx]) begin
                map[wr_idx] <= 1'b1;
                tower_count <= tower_count + 6'd1;
            end else if (!place_set && map[wr_idx]) begin
                map[wr_idx] <= 1'b0;
                tower_count <= tower_count - 6'd1;
            end
        end
    end

endmodule

// File: rtl/tower_grid_scheduler.sv
// Row-major refresh scanner: walks the occupancy map one cell per cycle and
// hands each occupied cell to the sprite drawer with a start/done handshake.
module tower_grid_scheduler
    import tower_grid_scheduler_pkg::*;
#(
    parameter int GRID_W = tower_grid_scheduler_pkg::GRID_W,
    parameter int GRID_H = tower_grid_scheduler_pkg::GRID_H
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       place_valid,
    input  logic       place_set,
    input  logic [3:0] place_x,
    input  logic [3:0] place_y,
    input  logic       refresh_req,
    input  logic       draw_done,
    output logic       draw_start,
    output logic [3:0] grid_x,
    output logic [3:0] grid_y,
    output logic       busy,
    output logic       frame_done,
    output logic [5:0] tower_count
);

    sched_state_t state;
    logic [3:0]   scan_x;
    logic [3:0]   scan_y;
    logic         cell_occ;
    logic         last_x;
    logic         last_cell;

    occupancy_map #(
        .GRID_W(GRID_W),
        .GRID_H(GRID_H)
    ) u_map (
        .clk        (clk),
        .reset      (reset),
        .place_valid(place_valid),
        .place_set  (place_set),
        .place_x    (place_x),
        .place_y    (place_y),
        .rd_x       (scan_x),
        .rd_y       (scan_y),
        .rd_bit     (cell_occ),
        .tower_count(tower_count)
    );

    assign last_x    = (scan_x == 4'(GRID_W - 1));
    assign last_cell = last_x && (scan_y == 4'(GRID_H - 1));
    assign grid_x    = scan_x;
    assign grid_y    = scan_y;

    // The scan index only moves when leaving SCAN or WAIT, which keeps
    // grid_x/grid_y steady for the whole drawer handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            scan_x     <= '0;
            scan_y     <= '0;
            draw_start <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            draw_start <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (refresh_req) begin
                        state  <= ST_SCAN;
                        scan_x <= '0;
                        scan_y <= '0;
                        busy   <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (cell_occ) begin
                        state      <= ST_START;
                        draw_start <= 1'b1;
                    end else if (last_cell) begin
                        state      <= ST_FINISH;
                        frame_done <= 1'b1;
                    end else if (last_x) begin
                        scan_x <= '0;
                        scan_y <= scan_y + 4'd1;
                    end else begin
                        scan_x <= scan_x + 4'd1;
                    end
                end
                ST_START: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (draw_done) begin
                        if (last_cell) begin
                            state      <= ST_FINISH;
                            frame_done <= 1'b1;
                        end else begin
                            state <= ST_SCAN;
                            if (last_x) begin
                                scan_x <= '0;
                                scan_y <= scan_y + 4'd1;
                            end else begin
                                scan_x <= scan_x + 4'd1;
                            end
                        end
                    end
                end
                ST_FINISH: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tower_grid_scheduler.sv
// Scoreboard bench for the tower grid scheduler: directed writes and refreshes,
// with expected drawer starts and frame ends checked by an independent monitor.
module tb_tower_grid_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       place_valid = 1'b0;
    logic       place_set = 1'b0;
    logic [3:0] place_x = '0;
    logic [3:0] place_y = '0;
    logic       refresh_req = 1'b0;
    logic       draw_done = 1'b0;
    logic       draw_start;
    logic [3:0] grid_x;
    logic [3:0] grid_y;
    logic       busy;
    logic       frame_done;
    logic [5:0] tower_count;

    typedef struct packed {
        logic       is_frame;
        logic [3:0] x;
        logic [3:0] y;
    } ev_t;

    ev_t sb[$];
    int  total = 0;
    int  bad = 0;
    bit  drawer_en = 1'b1;

    always #5 clk = ~clk;

    tower_grid_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .place_valid(place_valid),
        .place_set  (place_set),
        .place_x    (place_x),
        .place_y    (place_y),
        .refresh_req(refresh_req),
        .draw_done  (draw_done),
        .draw_start (draw_start),
        .grid_x     (grid_x),
        .grid_y     (grid_y),
        .busy       (busy),
        .frame_done (frame_done),
        .tower_count(tower_count)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic set, input logic [3:0] x, input logic [3:0] y);
        @(posedge clk);
        #1;
        place_valid = 1'b1;
        place_set   = set;
        place_x     = x;
        place_y     = y;
        @(posedge clk);
        #1;
        place_valid = 1'b0;
        place_set   = 1'b0;
        place_x     = '0;
        place_y     = '0;
    endtask

    task automatic pulseRefresh();
        @(posedge clk);
        #1 refresh_req = 1'b1;
        @(posedge clk);
        #1 refresh_req = 1'b0;
    endtask

    task automatic waitStart(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!draw_start && n < budget);
        checkOutput("start_timeout", int'(draw_start), 1);
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < budget);
        checkOutput("idle_timeout", int'(busy), 0);
    endtask

    task automatic pushStart(input logic [3:0] x, input logic [3:0] y);
        sb.push_back(ev_t'{is_frame: 1'b0, x: x, y: y});
    endtask

    task automatic pushFrame();
        sb.push_back(ev_t'{is_frame: 1'b1, x: 4'd0, y: 4'd0});
    endtask

    // Monitor: every start or frame pulse must match the oldest expected event.
    always @(negedge clk) begin : monitor
        ev_t e;
        logic ok;
        if (!reset && (draw_start || frame_done)) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("[TB] FAIL unexpected_event: got start=%0b frame=%0b x=%0d y=%0d, expected none",
                         draw_start, frame_done, grid_x, grid_y);
            end else begin
                e  = sb.pop_front();
                ok = e.is_frame ? (frame_done && !draw_start)
                                : (draw_start && !frame_done && grid_x == e.x && grid_y == e.y);
                if (!ok) begin
                    bad++;
                    $display("[TB] FAIL event: got start=%0b frame=%0b x=%0d y=%0d, expected frame=%0b x=%0d y=%0d",
                             draw_start, frame_done, grid_x, grid_y, e.is_frame, e.x, e.y);
                end
            end
        end
    end

    // Model drawer: answers five cycles after each start it sees.
    initial begin
        forever begin
            @(negedge clk);
            if (drawer_en && draw_start && !reset) begin
                repeat (5) @(posedge clk);
                #1 draw_done = 1'b1;
                @(posedge clk);
                #1 draw_done = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset state
        reset = 1'b1;
        #12;
        checkOutput("rst_draw_start", int'(draw_start), 0);
        checkOutput("rst_frame_done", int'(frame_done), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_grid_x", int'(grid_x), 0);
        checkOutput("rst_grid_y", int'(grid_y), 0);
        checkOutput("rst_count", int'(tower_count), 0);
        #5 reset = 1'b0;

        // Empty map: busy in cycles 1..49, frame_done only in cycle 49
        $display("[TB] empty map latency");
        pushFrame();
        pulseRefresh();
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            checkOutput($sformatf("empty_busy_c%0d", k + 1), int'(busy), (k <= 48) ? 1 : 0);
            checkOutput($sformatf("empty_frame_c%0d", k + 1), int'(frame_done), (k == 48) ? 1 : 0);
        end

        // Out-of-range writes are dropped
        $display("[TB] out of range writes");
        applyStimulus(1'b1, 4'd8, 4'd0);
        applyStimulus(1'b1, 4'd0, 4'd6);
        applyStimulus(1'b1, 4'd15, 4'd15);
        checkOutput("oor_count", int'(tower_count), 0);

        // Redundant set then clear
        $display("[TB] redundant writes");
        applyStimulus(1'b1, 4'd0, 4'd0);
        checkOutput("dup_count_1", int'(tower_count), 1);
        applyStimulus(1'b1, 4'd0, 4'd0);
        checkOutput("dup_count_2", int'(tower_count), 1);
        applyStimulus(1'b0, 4'd0, 4'd0);
        checkOutput("dup_count_3", int'(tower_count), 0);
        applyStimulus(1'b0, 4'd0, 4'd0);
        checkOutput("dup_count_4", int'(tower_count), 0);

        // Two towers drawn in row-major order
        $display("[TB] two tower scan");
        applyStimulus(1'b1, 4'd7, 4'd5);
        applyStimulus(1'b1, 4'd3, 4'd2);
        checkOutput("two_count_pre", int'(tower_count), 2);
        pushStart(4'd3, 4'd2);
        pushStart(4'd7, 4'd5);
        pushFrame();
        pulseRefresh();
        waitIdle(400);
        checkOutput("two_count_post", int'(tower_count), 2);
        checkOutput("two_queue_empty", sb.size(), 0);

        // Refresh and clear during WAIT must not disturb the handshake
        $display("[TB] refresh and clear during wait");
        applyStimulus(1'b0, 4'd3, 4'd2);
        applyStimulus(1'b0, 4'd7, 4'd5);
        applyStimulus(1'b1, 4'd1, 4'd1);
        checkOutput("wait_count_pre", int'(tower_count), 1);
        pushStart(4'd1, 4'd1);
        pushFrame();
        pulseRefresh();
        waitStart(100);
        @(posedge clk);
        #1;
        refresh_req = 1'b1;
        place_valid = 1'b1;
        place_set   = 1'b0;
        place_x     = 4'd1;
        place_y     = 4'd1;
        @(posedge clk);
        #1;
        refresh_req = 1'b0;
        place_valid = 1'b0;
        place_x     = '0;
        place_y     = '0;
        checkOutput("wait_count_cleared", int'(tower_count), 0);
        checkOutput("wait_busy", int'(busy), 1);
        checkOutput("wait_grid_x", int'(grid_x), 1);
        checkOutput("wait_grid_y", int'(grid_y), 1);
        waitIdle(200);
        repeat (60) @(negedge clk);
        checkOutput("wait_no_rescan", int'(busy), 0);
        checkOutput("wait_queue_empty", sb.size(), 0);

        // Asynchronous reset while waiting on the drawer
        $display("[TB] reset during wait");
        drawer_en = 1'b0;
        applyStimulus(1'b1, 4'd2, 4'd0);
        pushStart(4'd2, 4'd0);
        pulseRefresh();
        waitStart(100);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        checkOutput("arst_busy", int'(busy), 0);
        checkOutput("arst_draw_start", int'(draw_start), 0);
        checkOutput("arst_frame_done", int'(frame_done), 0);
        checkOutput("arst_grid_x", int'(grid_x), 0);
        checkOutput("arst_grid_y", int'(grid_y), 0);
        checkOutput("arst_count", int'(tower_count), 0);
        #2 reset = 1'b0;
        @(posedge clk);
        #1 draw_done = 1'b1;
        @(posedge clk);
        #1 draw_done = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("arst_done_ignored", int'(busy), 0);
        drawer_en = 1'b1;
        pushFrame();
        pulseRefresh();
        waitIdle(100);
        checkOutput("arst_final_count", int'(tower_count), 0);
        checkOutput("arst_queue_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
